// File: rtl/microsequencer_pkg.sv
// microsequencer_pkg
//   Shared definitions for the microsequencer:
//   - next-address mode encodings (N field)
//   - COND flag bit indices
//   - control-word field bit positions
//   Configuration macro: USEQ_RETURN_REG_EN (one-level call/return register).
package microsequencer_pkg;

  typedef enum logic [2:0] {
    N_DISPATCH = 3'b000,  // ENC_ADDR
    N_SEQ      = 3'b001,  // STATE+1
    N_JUMP     = 3'b010,  // CR
    N_CJUMP    = 3'b011,  // T ? CR : INC
    N_CDISP    = 3'b100,  // T ? CR : ENC_ADDR
    N_WAIT     = 3'b101,  // T ? INC : hold
    N_CALL     = 3'b110,  // RET <= INC, CR
    N_RET      = 3'b111   // RET
  } n_mode_e;

  localparam int COND_MOC       = 0;
  localparam int COND_PASS      = 1;
  localparam int COND_Z         = 2;
  localparam int COND_N         = 3;
  localparam int COND_C         = 4;
  localparam int COND_V         = 5;
  localparam int COND_LSM_DONE  = 6;
  localparam int COND_TRUE      = 7;

  localparam int CW_N_HI   = 58;
  localparam int CW_N_LO   = 56;
  localparam int CW_INV    = 55;
  localparam int CW_S_HI   = 53;
  localparam int CW_S_LO   = 51;
  localparam int CW_CR_HI  = 42;
  localparam int CW_CR_LO  = 35;

endpackage

// File: rtl/microsequencer_if.sv
// microsequencer_if
//   Control-word / status bundle between the control store and the sequencer.
//   master: drives the control-word fields, encoder address, flags and STALL.
//   slave : the sequencer; returns STATE (ROM address) and TAKEN.
interface microsequencer_if #(
  parameter int ADDR_W = 8,
  parameter int NCOND  = 8
);
  localparam int S_W = $clog2(NCOND);

  logic [2:0]        N;
  logic              INV;
  logic [S_W-1:0]    S;
  logic [ADDR_W-1:0] CR;
  logic [ADDR_W-1:0] ENC_ADDR;
  logic [NCOND-1:0]  COND;
  logic              STALL;
  logic [ADDR_W-1:0] STATE;
  logic              TAKEN;

  modport master (
    output N, INV, S, CR, ENC_ADDR, COND, STALL,
    input  STATE, TAKEN
  );

  modport slave (
    input  N, INV, S, CR, ENC_ADDR, COND, STALL,
    output STATE, TAKEN
  );
endinterface

// File: rtl/useq_next_sel.sv
// useq_next_sel
//   Combinational test-bit and next-address multiplexer.
//   Inputs : n_i (mode), inv_i, s_i (condition select), cr_i, enc_addr_i,
//            cond_i, state_i (current address), ret_i (macro only)
//   Outputs: next_o (selected address), taken_o (non-sequential target),
//            call_o (save INC into RET; macro only)
//   Macro USEQ_RETURN_REG_EN: enables call/return; otherwise CALL acts as
//   JUMP and RET acts as DISPATCH.
module useq_next_sel
  import microsequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NCOND  = 8,
  parameter int S_W    = $clog2(NCOND)
) (
  input  logic [2:0]        n_i,
  input  logic              inv_i,
  input  logic [S_W-1:0]    s_i,
  input  logic [ADDR_W-1:0] cr_i,
  input  logic [ADDR_W-1:0] enc_addr_i,
  input  logic [NCOND-1:0]  cond_i,
  input  logic [ADDR_W-1:0] state_i,
`ifdef USEQ_RETURN_REG_EN
  input  logic [ADDR_W-1:0] ret_i,
  output logic              call_o,
`endif
  output logic [ADDR_W-1:0] next_o,
  output logic              taken_o
);

  logic              t;
  logic [ADDR_W-1:0] inc;

  assign t   = cond_i[s_i] ^ inv_i;
  assign inc = state_i + ADDR_W'(1);  // wraps naturally at 2^ADDR_W

  always_comb begin
    next_o  = state_i;
    taken_o = 1'b0;
`ifdef USEQ_RETURN_REG_EN
    call_o  = 1'b0;
`endif
    case (n_mode_e'(n_i))
      N_DISPATCH: begin next_o = enc_addr_i; taken_o = 1'b1; end
      N_SEQ:      begin next_o = inc; end
      N_JUMP:     begin next_o = cr_i; taken_o = 1'b1; end
      N_CJUMP:    begin next_o = t ? cr_i : inc; taken_o = t; end
      N_CDISP:    begin next_o = t ? cr_i : enc_addr_i; taken_o = 1'b1; end
      N_WAIT:     begin next_o = t ? inc : state_i; end
`ifdef USEQ_RETURN_REG_EN
      N_CALL:     begin next_o = cr_i; taken_o = 1'b1; call_o = 1'b1; end
      N_RET:      begin next_o = ret_i; taken_o = 1'b1; end
`else
      N_CALL:     begin next_o = cr_i; taken_o = 1'b1; end
      N_RET:      begin next_o = enc_addr_i; taken_o = 1'b1; end
`endif
      default:    begin next_o = state_i; end
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer
//   Microprogram sequencer: owns STATE (control ROM address), TAKEN and the
//   one-level return register RET.
//   Ports: CLK, RESET (synchronous, active high, wins over STALL),
//          bus (microsequencer_if.slave: control-word fields, ENC_ADDR,
//          COND, STALL in; STATE, TAKEN out).
//   Macro USEQ_RETURN_REG_EN: when defined, RET exists and N=110/111 are
//   call/return; when undefined they behave as jump/dispatch.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NCOND  = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  microsequencer_if.slave bus
);

  localparam int S_W = $clog2(NCOND);

  logic [ADDR_W-1:0] state_q, state_d;
  logic              taken_q, taken_d;
`ifdef USEQ_RETURN_REG_EN
  logic [ADDR_W-1:0] ret_q;
  logic              call;
`endif

  useq_next_sel #(
    .ADDR_W (ADDR_W),
    .NCOND  (NCOND),
    .S_W    (S_W)
  ) u_next_sel (
    .n_i        (bus.N),
    .inv_i      (bus.INV),
    .s_i        (bus.S),
    .cr_i       (bus.CR),
    .enc_addr_i (bus.ENC_ADDR),
    .cond_i     (bus.COND),
    .state_i    (state_q),
`ifdef USEQ_RETURN_REG_EN
    .ret_i      (ret_q),
    .call_o     (call),
`endif
    .next_o     (state_d),
    .taken_o    (taken_d)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= '0;
      taken_q <= 1'b0;
`ifdef USEQ_RETURN_REG_EN
      ret_q   <= '0;
`endif
    end else if (!bus.STALL) begin
      state_q <= state_d;
      taken_q <= taken_d;
`ifdef USEQ_RETURN_REG_EN
      if (call) ret_q <= state_q + ADDR_W'(1);
`endif
    end
  end

  assign bus.STATE = state_q;
  assign bus.TAKEN = taken_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer
//   Directed scenarios plus randomized control words, checked against a
//   behavioural model of the next-address rules.
module tb_microsequencer;
  localparam int ADDR_W = 8;
  localparam int NCOND  = 8;
  localparam int AMOD   = 1 << ADDR_W;

  logic CLK = 1'b0;
  logic RESET;

  microsequencer_if #(.ADDR_W(ADDR_W), .NCOND(NCOND)) bus ();

  microsequencer #(.ADDR_W(ADDR_W), .NCOND(NCOND)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int m_state = 0;
  int m_ret   = 0;
  int m_taken = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit stall, input int n, input bit inv,
                       input int s, input int cr, input int enc, input int cond);
    RESET        = rst;
    bus.STALL    = stall;
    bus.N        = 3'(n);
    bus.INV      = inv;
    bus.S        = 3'(s);
    bus.CR       = 8'(cr);
    bus.ENC_ADDR = 8'(enc);
    bus.COND     = 8'(cond) | 8'h80;
  endtask

  // Next-address rules applied to the model's own state
  task automatic model_step();
    int t, inc, cr, enc, nxt, tk;
    if (RESET) begin
      m_state = 0; m_ret = 0; m_taken = 0;
      return;
    end
    if (bus.STALL) return;
    t   = ((int'(bus.COND) >> int'(bus.S)) & 1) ^ int'(bus.INV);
    inc = (m_state + 1) % AMOD;
    cr  = int'(bus.CR);
    enc = int'(bus.ENC_ADDR);
    nxt = m_state;
    tk  = 0;
    case (int'(bus.N))
      0: begin nxt = enc; tk = 1; end
      1: begin nxt = inc; tk = 0; end
      2: begin nxt = cr;  tk = 1; end
      3: begin nxt = (t != 0) ? cr : inc; tk = t; end
      4: begin nxt = (t != 0) ? cr : enc; tk = 1; end
      5: begin nxt = (t != 0) ? inc : m_state; tk = 0; end
      6: begin
`ifdef USEQ_RETURN_REG_EN
           m_ret = inc;
`endif
           nxt = cr; tk = 1;
         end
      default: begin
`ifdef USEQ_RETURN_REG_EN
           nxt = m_ret;
`else
           nxt = enc;
`endif
           tk = 1;
         end
    endcase
    m_state = nxt;
    m_taken = tk;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check({tag, ".state"}, 32'(bus.STATE), 32'(m_state));
    check({tag, ".taken"}, 32'(bus.TAKEN), 32'(m_taken));
  endtask

  initial begin
    // Reset two cycles with N=001, then count up
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    cycle("rst0");
    cycle("rst1");
    check("rst_state_const", 32'(bus.STATE), 0);
    check("rst_taken_const", 32'(bus.TAKEN), 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle("seq");
      check("seq_const", 32'(bus.STATE), 32'(i));
    end

    // Wait loop on MOC at STATE=3
    drive(0, 0, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle("wait_hold");
      check("wait_hold_const", 32'(bus.STATE), 3);
    end
    drive(0, 0, 5, 0, 0, 0, 0, 1);
    cycle("wait_go");
    check("wait_go_const", 32'(bus.STATE), 4);

    // Conditional jump on COND_PASS, then inverted
    drive(0, 0, 3, 0, 1, 25, 0, 2);
    cycle("cjump_t");
    check("cjump_t_const", 32'(bus.STATE), 25);
    check("cjump_t_taken", 32'(bus.TAKEN), 1);
    drive(0, 0, 3, 1, 1, 25, 0, 2);
    cycle("cjump_f");
    check("cjump_f_const", 32'(bus.STATE), 26);
    check("cjump_f_taken", 32'(bus.TAKEN), 0);

    // Call from 40 to 42, then return
    drive(0, 0, 2, 0, 0, 40, 0, 0);
    cycle("jump40");
    drive(0, 0, 6, 0, 0, 42, 0, 0);
    cycle("call");
    check("call_const", 32'(bus.STATE), 42);
    drive(0, 0, 7, 0, 0, 0, 77, 0);
    cycle("ret");
`ifdef USEQ_RETURN_REG_EN
    check("ret_const", 32'(bus.STATE), 41);
`else
    check("ret_const", 32'(bus.STATE), 77);
`endif

    // Wrap at 255, then stall holds
    drive(0, 0, 2, 0, 0, 255, 0, 0);
    cycle("jump255");
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    cycle("wrap");
    check("wrap_const", 32'(bus.STATE), 0);
    drive(0, 1, 2, 0, 0, 10, 0, 0);
    cycle("stall0");
    check("stall_const", 32'(bus.STATE), 0);
    drive(0, 0, 2, 0, 0, 100, 0, 0);
    cycle("jump100");
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    cycle("stall1");
    check("stall_taken_const", 32'(bus.TAKEN), 1);

    // Reset wins over stall
    drive(1, 1, 0, 0, 0, 0, 16, 0);
    cycle("rst_stall");
    check("rst_stall_const", 32'(bus.STATE), 0);

    // Return with no prior call after reset
    drive(0, 0, 7, 0, 0, 0, 99, 0);
    cycle("ret_nocall");
`ifdef USEQ_RETURN_REG_EN
    check("ret_nocall_const", 32'(bus.STATE), 0);
`else
    check("ret_nocall_const", 32'(bus.STATE), 99);
`endif

    // Reset during a pending call and during a wait
    drive(0, 0, 2, 0, 0, 60, 0, 0);
    cycle("jump60");
    drive(1, 0, 6, 0, 0, 70, 0, 0);
    cycle("rst_call");
    drive(0, 0, 7, 0, 0, 0, 5, 0);
    cycle("ret_after_rst");
    drive(0, 0, 5, 0, 0, 0, 0, 0);
    cycle("wait_pre");
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    cycle("rst_wait");
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    cycle("restart");

    // Randomized control words
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 15),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the width of the microstore address and of every address port.
REQ-002 The block SHALL have parameter NCOND, default 8, giving the number of selectable test conditions; it is fixed at 2^width(S).
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 N  input  3  next-address mode field of the current control word (bits 58:56).
REQ-006 INV  input  1  condition invert bit of the current control word (bit 55).
REQ-007 S  input  3  condition select field of the current control word (bits 53:51).
REQ-008 CR  input  ADDR_W  literal target address (CR7..CR0, bits 42:35).
REQ-009 ENC_ADDR  input  ADDR_W  dispatch address from the instruction encoder.
REQ-010 COND  input  NCOND  test flags: [0] MOC, [1] COND_PASS, [2] Z, [3] N, [4] C, [5] V, [6] LSM_DONE, [7] tied 1.
REQ-011 STALL  input  1  when high, holds every register.
REQ-012 STATE  output  ADDR_W  registered current microstore address; drives the control ROM address input.
REQ-013 TAKEN  output  1  registered; high when the last update selected a non-sequential target.

Function
REQ-014 The test bit SHALL be T = COND[S] XOR INV, combinational from the current inputs.
REQ-015 The incrementer SHALL be INC = STATE+1 mod 2^ADDR_W; STATE=255 SHALL wrap to 0.
REQ-016 Next address by N:
- 000 SHALL select ENC_ADDR.
- 001 SHALL select INC.
- 010 SHALL select CR.
- 011 SHALL select CR if T, else INC.
- 100 SHALL select CR if T, else ENC_ADDR.
- 101 SHALL select INC if T, else hold STATE (wait loop).
- 110 SHALL be a call: save INC into RET, select CR.
- 111 SHALL be a return: select RET.
REQ-017 With STALL=0, STATE SHALL take the selected address on the next rising edge: one-cycle latency from control word to new address.
REQ-018 With STALL=1, STATE, RET and TAKEN SHALL hold, whatever N and T are.
REQ-019 TAKEN SHALL be 1 after an update that selected CR, ENC_ADDR or RET; it SHALL be 0 after an update that selected INC or held.
REQ-020 RET SHALL be one level deep; a second call before a return SHALL overwrite it.
REQ-021 A return with no prior call SHALL select RET's reset value, 0.
REQ-022 Control-word fields SHALL be consumed only in the cycle STATE presents them; no fields SHALL be buffered.

Reset
REQ-023 While RESET=1 at a rising edge, STATE SHALL become 0, RET 0 and TAKEN 0; RESET SHALL take priority over STALL.
REQ-024 A reset asserted mid-wait (N=101) or mid-call SHALL discard the pending operation; the sequence SHALL restart at address 0 the cycle after RESET falls.

Configuration
REQ-025 Macro USEQ_RETURN_REG_EN defined: RET and call/return SHALL behave as in REQ-016, REQ-020 and REQ-021.
REQ-026 Macro USEQ_RETURN_REG_EN undefined: RET SHALL not exist; N=110 SHALL act as 010 and N=111 as 000.

Structure
REQ-027 A shared package SHALL hold:
- the N mode encodings;
- the COND bit indices;
- the control-word field bit positions: N 58:56, INV 55, S 53:51, CR 42:35.
REQ-028 Sub-module useq_next_sel SHALL be the combinational T/mode multiplexer; the parent SHALL own the STATE, RET and TAKEN registers.

Verification
REQ-029 RESET high for 2 cycles, then N=001 -> STATE=0 during reset, then 1, 2, 3 on successive edges; TAKEN=0.
REQ-030 STATE=3, N=101, S=0, INV=0, MOC=0 for 4 cycles then 1 -> STATE holds 3 for 4 cycles, then 4.
REQ-031 N=011, S=1, CR=25: COND_PASS=1 -> STATE=25, TAKEN=1; INV=1 with the same inputs -> STATE=INC, TAKEN=0.
REQ-032 STATE=40, N=110, CR=42, then N=111 at 42 -> STATE 42 then 41 with the macro defined; STATE=42 then ENC_ADDR without it.
REQ-033 STATE=255, N=001 -> STATE=0; STALL=1 with N=010, CR=10 -> STATE unchanged.
REQ-034 N=000, ENC_ADDR=16, RESET and STALL both high in the same cycle -> STATE=0.
